video_stream_gen: RTL

// Frame source for the gray/RAW processing chain: generates vsync/href timing and an 8-bit

---
 rtl/vid_pkg.sv | 20 ++
 rtl/video_stream_gen_if.sv | 10 +
 rtl/vid_pattern_gen.sv | 24 ++
 rtl/video_stream_gen.sv | 135 +++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared types for the video test-frame source: FSM states and test-pattern codes.
`timescale 1ns/1ps
package vid_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRONT  = 3'd1,
    LEAD   = 3'd2,
    ACTIVE = 3'd3,
    TAIL   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_MOVE  = 2'd3
  } pat_e;

endpackage

// File: rtl/video_stream_gen_if.sv
// Frame-timing and pixel bus between the frame source and the gray/RAW processing chain.
`timescale 1ns/1ps
interface video_stream_gen_if;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic [7:0] post_img_RAW;

  modport master (output post_frame_vsync, output post_frame_href, output post_img_RAW);
  modport slave  (input  post_frame_vsync, input  post_frame_href, input  post_img_RAW);
endinterface

// File: rtl/vid_pattern_gen.sv
// Combinational test-pattern lookup: pixel position, frame count and pattern code -> 8-bit pixel.
`timescale 1ns/1ps
module vid_pattern_gen
  import vid_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [7:0] frame_cnt,
  input  pat_e       pattern,
  output logic [7:0] pixel
);

  always_comb begin
    pixel = 8'h00;
    case (pattern)
      PAT_HRAMP: pixel = x;
      PAT_VRAMP: pixel = y;
      PAT_CHECK: pixel = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      PAT_MOVE:  pixel = x + frame_cnt;
      default:   pixel = 8'h00;
    endcase
  end

endmodule

// File: rtl/video_stream_gen.sv
// Camera-replacement frame source: vsync/href timing FSM plus registered test-pattern pixels.
`timescale 1ns/1ps
module video_stream_gen
  import vid_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [10:0] H_BLANK   = 11'd160,
  parameter logic [15:0] V_FRONT   = 16'd800,
  parameter logic [15:0] V_LEAD    = 16'd800,
  parameter logic [15:0] V_TAIL    = 16'd800
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           pattern_sel,
  video_stream_gen_if.master   vid,
  output logic                 frame_done,
  output logic [7:0]           frame_cnt
);

  state_e      state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [10:0] x_q, x_d, y_q, y_d, hb_q, hb_d;
  logic        blank_q, blank_d;
  logic        done_d, href_d;
  pat_e        pat_q;
  logic [7:0]  pix_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outputs are decoded from the next-state values so that the registered
  // vsync/href/pixel line up exactly with the state they describe.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    hb_d    = hb_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FRONT;
          phase_d = '0;
        end
      end
      FRONT: begin
        if (phase_q == V_FRONT - 16'd1) begin
          state_d = LEAD;
          phase_d = '0;
        end else phase_d = phase_q + 16'd1;
      end
      LEAD: begin
        if (phase_q == V_LEAD - 16'd1) begin
          state_d = ACTIVE;
          phase_d = '0;
          x_d     = '0;
          y_d     = '0;
          hb_d    = '0;
          blank_d = 1'b0;
        end else phase_d = phase_q + 16'd1;
      end
      ACTIVE: begin
        if (!blank_q) begin
          if (x_q == IMG_HDISP - 11'd1) begin
            blank_d = 1'b1;
            hb_d    = '0;
            x_d     = '0;
          end else x_d = x_q + 11'd1;
        end else if (hb_q == H_BLANK - 11'd1) begin
          blank_d = 1'b0;
          hb_d    = '0;
          if (y_q == IMG_VDISP - 11'd1) begin
            state_d = TAIL;
            y_d     = '0;
            phase_d = '0;
          end else y_d = y_q + 11'd1;
        end else hb_d = hb_q + 11'd1;
      end
      TAIL: begin
        if (phase_q == V_TAIL - 16'd1) begin
          state_d = enable ? FRONT : IDLE;
          phase_d = '0;
          done_d  = 1'b1;
        end else phase_d = phase_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign href_d = (state_d == ACTIVE) && !blank_d;

  vid_pattern_gen u_pat (
    .x         (x_d[7:0]),
    .y         (y_d[7:0]),
    .frame_cnt (frame_cnt),
    .pattern   (pat_q),
    .pixel     (pix_p0)
  );

  // Register boundary: counters, latched pattern and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q              <= '0;
      x_q                  <= '0;
      y_q                  <= '0;
      hb_q                 <= '0;
      blank_q              <= 1'b0;
      pat_q                <= PAT_HRAMP;
      vid.post_frame_vsync <= 1'b0;
      vid.post_frame_href  <= 1'b0;
      vid.post_img_RAW     <= 8'h00;
      frame_done           <= 1'b0;
      frame_cnt            <= 8'h00;
    end else begin
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hb_q    <= hb_d;
      blank_q <= blank_d;
      if (state_q == FRONT && state_d == LEAD) pat_q <= pat_e'(pattern_sel);
      vid.post_frame_vsync <= (state_d == LEAD) || (state_d == ACTIVE) || (state_d == TAIL);
      vid.post_frame_href  <= href_d;
      vid.post_img_RAW     <= href_d ? pix_p0 : 8'h00;
      frame_done           <= done_d;
      if (done_d) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule
